// File: rtl/scope_acq_pkg.sv
// Shared encodings for the acquisition sequencer: FSM states and event vector bit positions.
package scope_acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } acq_state_e;

  localparam int EV_TRIG = 0;
  localparam int EV_DONE = 1;
  localparam int EV_MISS = 2;
  localparam int EV_W    = 3;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edge.
// Level appears STAGES edges after the input; rise_o is high for one cycle with it.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/scope_acq_event_gen.sv
// Acquisition sequencer: arm -> wait for trigger -> count CAPTURE_DEPTH samples -> wait for ack.
// Drives the capture RAM write port and a sticky 3-bit event vector polled by the CPU.
module scope_acq_event_gen
  import scope_acq_pkg::*;
#(
  parameter int CAPTURE_DEPTH = 1024,
  parameter int SAMPLE_CNT_W  = 11,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    ack,
  input  logic                    trig_in,
  input  logic                    sample_valid,
  output logic [EV_W-1:0]         event_out,
  output logic [1:0]              state_out,
  output logic [SAMPLE_CNT_W-1:0] sample_count,
  output logic                    capture_we,
  output logic [SAMPLE_CNT_W-1:0] capture_addr
);

  localparam logic [SAMPLE_CNT_W-1:0] LAST_IDX = SAMPLE_CNT_W'(CAPTURE_DEPTH - 1);

  acq_state_e              state_q, state_d;
  logic [SAMPLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [EV_W-1:0]         ev_q, ev_d, ev_set;
  logic                    arm_q, ack_q;
  logic                    arm_rise, ack_rise, trig_rise;

  sync_rise_detect #(
    .STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (trig_in),
    .level_o (),
    .rise_o  (trig_rise)
  );

  // arm/ack come from a PIO in the clk domain, so a single register suffices.
  assign arm_rise = arm & ~arm_q;
  assign ack_rise = ack & ~ack_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ev_q    <= '0;
      arm_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      arm_q   <= arm;
      ack_q   <= ack;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_set  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arm_rise) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_rise) begin
          state_d         = ST_CAPTURE;
          cnt_d           = '0;
          ev_set[EV_TRIG] = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (trig_rise) ev_set[EV_MISS] = 1'b1;
        if (sample_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d         = ST_DONE;
            ev_set[EV_DONE] = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (trig_rise) ev_set[EV_MISS] = 1'b1;
        if (ack_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A set in the same cycle as the ack outlives the clear.
    ev_d = (ack_rise ? '0 : ev_q) | ev_set;
  end

  assign state_out    = state_q;
  assign event_out    = ev_q;
  assign sample_count = cnt_q;
  assign capture_addr = cnt_q;
  assign capture_we   = (state_q == ST_CAPTURE) & sample_valid;

endmodule

// File: tb/tb_scope_acq_event_gen.sv
// Directed bench for scope_acq_event_gen with a cycle-level behavioural model checked every negedge.
module tb_scope_acq_event_gen;

  localparam int D = 4;
  localparam int W = 11;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         arm = 1'b0, ack = 1'b0, trig_in = 1'b0, sample_valid = 1'b0;
  logic [2:0]   event_out;
  logic [1:0]   state_out;
  logic [W-1:0] sample_count;
  logic         capture_we;
  logic [W-1:0] capture_addr;

  int n_vec = 0;
  int n_err = 0;

  scope_acq_event_gen #(
    .CAPTURE_DEPTH (D),
    .SAMPLE_CNT_W  (W),
    .SYNC_STAGES   (S)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .ack          (ack),
    .trig_in      (trig_in),
    .sample_valid (sample_valid),
    .event_out    (event_out),
    .state_out    (state_out),
    .sample_count (sample_count),
    .capture_we   (capture_we),
    .capture_addr (capture_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: trig_in is known only through its values at clock edges;
  // a trigger acts S edges after the first edge that saw it high (and low the edge before).
  int   m_state = 0;
  int   m_cnt   = 0;
  logic [2:0] m_ev = 3'b000;
  logic m_arm_prev = 1'b0, m_ack_prev = 1'b0;
  logic hist[$];
  bit   m_init = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    logic arm_r, ack_r, trig_r;
    logic [2:0] nev;
    if (!reset_n) begin
      m_state = 0; m_cnt = 0; m_ev = 3'b000;
      m_arm_prev = 1'b0; m_ack_prev = 1'b0;
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(1'b0);
      m_init = 1'b1;
    end else if (m_init) begin
      arm_r  = arm & ~m_arm_prev;
      ack_r  = ack & ~m_ack_prev;
      trig_r = hist[hist.size()-S] & ~hist[hist.size()-S-1];
      nev    = ack_r ? 3'b000 : m_ev;
      if (m_state == 0) begin
        if (arm_r) m_state = 1;
      end else if (m_state == 1) begin
        if (trig_r) begin m_state = 2; m_cnt = 0; nev[0] = 1'b1; end
      end else if (m_state == 2) begin
        if (trig_r) nev[2] = 1'b1;
        if (sample_valid) begin
          m_cnt++;
          if (m_cnt == D) begin m_state = 3; nev[1] = 1'b1; end
        end
      end else begin
        if (trig_r) nev[2] = 1'b1;
        if (ack_r) m_state = 0;
      end
      m_ev = nev;
      m_arm_prev = arm;
      m_ack_prev = ack;
      hist.push_back(trig_in);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_state", 32'(state_out), 32'(m_state));
      chk("m_event", 32'(event_out), 32'(m_ev));
      chk("m_count", 32'(sample_count), 32'(m_cnt));
      chk("m_addr", 32'(capture_addr), 32'(m_cnt));
      chk("m_we", 32'(capture_we), 32'((m_state == 2) && sample_valid && reset_n));
    end
  end

  bit glitch_en = 1'b0;
  int glitch_rises = 0;
  always @(negedge clk) if (glitch_en && u_dut.trig_rise) glitch_rises++;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick(); tick();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_event", 32'(event_out), 0);
    chk("rst_count", 32'(sample_count), 0);
    chk("rst_we", 32'(capture_we), 0);
    chk("rst_addr", 32'(capture_addr), 0);
    reset_n = 1'b1;

    // Nominal run
    tick(); arm = 1'b1;
    tick(); arm = 1'b0;
    chk("arm_1clk", 32'(state_out), 1);
    trig_in = 1'b1;
    tick(); chk("trig_lat1", 32'(state_out), 1);
    tick(); chk("trig_lat2", 32'(state_out), 1);
    tick(); chk("trig_lat3", 32'(state_out), 2);
    chk("trig_ev", 32'(event_out), 32'h1);
    sample_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      chk("nom_we", 32'(capture_we), 1);
      chk("nom_addr", 32'(capture_addr), 32'(i));
      tick();
    end
    sample_valid = 1'b0;
    chk("nom_state", 32'(state_out), 3);
    chk("nom_count", 32'(sample_count), 4);
    chk("nom_ev", 32'(event_out), 32'h3);

    // Ack
    ack = 1'b1;
    tick(); ack = 1'b0; trig_in = 1'b0;
    chk("ack_state", 32'(state_out), 0);
    chk("ack_ev", 32'(event_out), 0);
    chk("ack_count", 32'(sample_count), 4);

    // Missed trigger
    tick(); tick(); arm = 1'b1;
    tick(); arm = 1'b0; trig_in = 1'b1;
    repeat (3) tick();
    chk("miss_cap", 32'(state_out), 2);
    sample_valid = 1'b1; tick(); tick();
    sample_valid = 1'b0; trig_in = 1'b0; tick(); tick();
    trig_in = 1'b1; repeat (3) tick();
    sample_valid = 1'b1; tick(); tick();
    sample_valid = 1'b0;
    chk("miss_state", 32'(state_out), 3);
    chk("miss_ev", 32'(event_out), 32'h7);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("miss_ack_ev", 32'(event_out), 0);
    trig_in = 1'b0; tick(); tick();
    trig_in = 1'b1; repeat (4) tick();
    chk("idle_trig_ev", 32'(event_out), 0);
    chk("idle_trig_st", 32'(state_out), 0);

    // Ignored inputs and collisions
    trig_in = 1'b0; arm = 1'b1;
    tick(); arm = 1'b0;
    chk("ign_armed", 32'(state_out), 1);
    sample_valid = 1'b1; #1;
    chk("ign_we_armed", 32'(capture_we), 0);
    tick(); sample_valid = 1'b0;
    chk("ign_cnt_armed", 32'(sample_count), 4);
    trig_in = 1'b1; repeat (3) tick();
    chk("ign_cap", 32'(state_out), 2);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("ign_arm_cap", 32'(state_out), 2);
    sample_valid = 1'b1; tick(); tick(); tick();
    ack = 1'b1; tick();
    chk("col_done_st", 32'(state_out), 3);
    chk("col_done_ev", 32'(event_out), 32'h2);
    chk("col_done_cnt", 32'(sample_count), 4);
    sample_valid = 1'b0; ack = 1'b0; trig_in = 1'b0;
    tick(); tick();
    trig_in = 1'b1; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("col_miss_st", 32'(state_out), 0);
    chk("col_miss_ev", 32'(event_out), 32'h4);

    // Reset mid-capture
    trig_in = 1'b0; tick(); tick(); arm = 1'b1;
    tick(); arm = 1'b0; trig_in = 1'b1;
    repeat (3) tick();
    sample_valid = 1'b1; tick(); tick();
    chk("rmid_count", 32'(sample_count), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_state", 32'(state_out), 0);
    chk("rmid_count0", 32'(sample_count), 0);
    chk("rmid_ev", 32'(event_out), 0);
    chk("rmid_we", 32'(capture_we), 0);
    sample_valid = 1'b0; trig_in = 1'b0;
    tick(); reset_n = 1'b1;
    tick(); arm = 1'b1;
    tick(); arm = 1'b0; trig_in = 1'b1;
    repeat (3) tick();
    chk("rerun_cap", 32'(state_out), 2);
    sample_valid = 1'b1; #1;
    chk("rerun_addr0", 32'(capture_addr), 0);
    chk("rerun_we", 32'(capture_we), 1);
    tick(); tick(); tick(); tick();
    sample_valid = 1'b0;
    chk("rerun_done", 32'(state_out), 3);
    ack = 1'b1; tick(); ack = 1'b0;

    // Glitches on trig_in
    trig_in = 1'b0; arm = 1'b1;
    tick(); arm = 1'b0;
    tick(); tick();
    glitch_en = 1'b1;
    #1 trig_in = 1'b1; #3 trig_in = 1'b0;
    repeat (4) tick();
    chk("glitch_short", 32'(state_out), 1);
    #5 trig_in = 1'b1; #4 trig_in = 1'b0;
    repeat (4) tick();
    glitch_en = 1'b0;
    chk("glitch_state", 32'(state_out), 2);
    chk("glitch_ev", 32'(event_out), 32'h1);
    chk("glitch_rises", 32'(glitch_rises), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
